// File: rtl/axis_word_serializer.sv
// AXI-Stream wide-to-word serializer: emits kept words of each input beat in ascending index order.
// Optional statistics counters are enabled with AXIS_WORD_SERIALIZER_STATS_EN.
module axis_word_serializer #(
  parameter int WORD_WIDTH = 16,
  parameter int BUS_WIDTH  = 64,
  localparam int WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH
) (
  input  logic                      aclk,
  input  logic                      areset,
  output logic                      s_ready,
  input  logic                      s_valid,
  input  logic                      s_last,
  input  logic [BUS_WIDTH-1:0]      s_data,
  input  logic [WORDS_PER_BEAT-1:0] s_keep,
  input  logic                      m_ready,
  output logic                      m_valid,
  output logic                      m_last,
  output logic [WORD_WIDTH-1:0]     m_data,
  output logic                      m_keep
`ifdef AXIS_WORD_SERIALIZER_STATS_EN
  ,
  output logic [31:0]               o_word_count,
  output logic [31:0]               o_pkt_count
`endif
);

  // state  | meaning
  // IDLE   | no beat held, ready for a new input beat
  // SERIAL | presenting remaining kept words (or a null-last beat)
  typedef enum logic {IDLE, SERIAL} state_t;

  localparam int IDX_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

  state_t                    state_q, state_d;
  logic [BUS_WIDTH-1:0]      data_q, data_d;
  logic [WORDS_PER_BEAT-1:0] keep_q, keep_d;
  logic                      last_q, last_d;
  logic                      null_q, null_d;
  logic                      m_valid_q, m_valid_d;
  logic                      m_last_q, m_last_d;
  logic                      m_keep_q, m_keep_d;
  logic [WORD_WIDTH-1:0]     m_data_q, m_data_d;
  logic                      rst_done_q;

  logic                      one_left;
  logic                      m_hs;
  logic                      s_hs;
  logic [IDX_W-1:0]          cur_idx;
  logic [IDX_W-1:0]          nxt_idx;

  function automatic logic [IDX_W-1:0] low_idx(input logic [WORDS_PER_BEAT-1:0] k);
    low_idx = '0;
    for (int i = WORDS_PER_BEAT - 1; i >= 0; i--) begin
      if (k[i]) low_idx = IDX_W'(i);
    end
  endfunction

  assign cur_idx  = low_idx(keep_q);
  assign one_left = null_q || ($countones(keep_q) == 1);
  assign m_hs     = m_valid_q && m_ready;
  // In SERIAL the slave side opens only while the final word is leaving, so beats chain without bubbles.
  assign s_ready  = rst_done_q && ((state_q == IDLE) || (m_ready && one_left));
  assign s_hs     = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    null_d  = null_q;
    nxt_idx = '0;

    if ((state_q == SERIAL) && m_hs) begin
      if (one_left) begin
        state_d = IDLE;
        keep_d  = '0;
        last_d  = 1'b0;
        null_d  = 1'b0;
      end else begin
        keep_d[cur_idx] = 1'b0;
      end
    end

    // An all-zero keep beat without last carries nothing and is dropped on the floor.
    if (s_hs && ((s_keep != '0) || s_last)) begin
      state_d = SERIAL;
      data_d  = s_data;
      keep_d  = s_keep;
      last_d  = s_last;
      null_d  = (s_keep == '0);
    end

    nxt_idx   = low_idx(keep_d);
    m_valid_d = (state_d == SERIAL);
    m_keep_d  = (state_d == SERIAL) && !null_d;
    m_last_d  = (state_d == SERIAL) && last_d && (null_d || ($countones(keep_d) == 1));
    m_data_d  = ((state_d == SERIAL) && !null_d) ? data_d[nxt_idx*WORD_WIDTH +: WORD_WIDTH] : '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      null_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_keep_q   <= 1'b0;
      m_data_q   <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      null_q     <= null_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_keep_q   <= m_keep_d;
      m_data_q   <= m_data_d;
      rst_done_q <= 1'b1;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_keep  = m_keep_q;
  assign m_data  = m_data_q;

`ifdef AXIS_WORD_SERIALIZER_STATS_EN
  logic [31:0] word_count_q, word_count_d;
  logic [31:0] pkt_count_q, pkt_count_d;

  always_comb begin
    word_count_d = word_count_q + ((m_hs && m_keep_q) ? 32'd1 : 32'd0);
    pkt_count_d  = pkt_count_q + ((m_hs && m_last_q) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      word_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      word_count_q <= word_count_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign o_word_count = word_count_q;
  assign o_pkt_count  = pkt_count_q;
`endif

endmodule

// File: tb/tb_axis_word_serializer.sv
// Directed self-checking bench for axis_word_serializer (4 x 16-bit words per beat).
module tb_axis_word_serializer;
  logic        aclk;
  logic        areset;
  logic        s_ready;
  logic        s_valid;
  logic        s_last;
  logic [63:0] s_data;
  logic [3:0]  s_keep;
  logic        m_ready;
  logic        m_valid;
  logic        m_last;
  logic [15:0] m_data;
  logic        m_keep;
`ifdef AXIS_WORD_SERIALIZER_STATS_EN
  logic [31:0] o_word_count;
  logic [31:0] o_pkt_count;
`endif

  axis_word_serializer #(.WORD_WIDTH(16), .BUS_WIDTH(64)) dut (
    .aclk(aclk), .areset(areset),
    .s_ready(s_ready), .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_keep(s_keep),
    .m_ready(m_ready), .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .m_keep(m_keep)
`ifdef AXIS_WORD_SERIALIZER_STATS_EN
    , .o_word_count(o_word_count), .o_pkt_count(o_pkt_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  int          acc_t = 0;
  bit          s_acc = 1'b0;
  logic [15:0] out_d[$];
  bit          out_l[$];
  bit          out_k[$];
  int          out_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_out();
    out_d.delete(); out_l.delete(); out_k.delete(); out_t.delete();
  endtask

  // One clock cycle: record handshakes just before the edge, return at edge+1.
  task automatic cyc();
    #1;
    if (m_valid && m_ready) begin
      out_d.push_back(m_data); out_l.push_back(m_last);
      out_k.push_back(m_keep); out_t.push_back(cyc_n);
    end
    s_acc = s_valid && s_ready;
    @(posedge aclk);
    #1;
    cyc_n++;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    do begin
      cyc();
      n++;
    end while (!s_acc && n < 50);
    chk("beat_accepted", {31'd0, s_acc}, 32'd1);
    acc_t = cyc_n - 1;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
  endtask

  initial begin
    int acc0;
    int b;
    int n;
    int lasts;
    areset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0; m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_m_keep", {31'd0, m_keep}, 32'd0);
    chk("rst_m_data", {16'd0, m_data}, 32'd0);
`ifdef AXIS_WORD_SERIALIZER_STATS_EN
    chk("rst_word_count", o_word_count, 32'd0);
    chk("rst_pkt_count", o_pkt_count, 32'd0);
`endif
    areset = 1'b0;
    #1;
    chk("s_ready_same_cycle_as_release", {31'd0, s_ready}, 32'd0);
    cyc();
    chk("s_ready_after_release", {31'd0, s_ready}, 32'd1);

    // Full beats, back to back
    m_ready = 1'b1;
    clear_out();
    send_beat({16'd3, 16'd2, 16'd1, 16'd0}, 4'hF, 1'b0);
    acc0 = acc_t;
    send_beat({16'd7, 16'd6, 16'd5, 16'd4}, 4'hF, 1'b0);
    chk("beat1_accept_cycle", acc_t, acc0 + 4);
    send_beat({16'd11, 16'd10, 16'd9, 16'd8}, 4'hF, 1'b1);
    chk("beat2_accept_cycle", acc_t, acc0 + 8);
    repeat (6) cyc();
    chk("full_count", out_d.size(), 12);
    if (out_d.size() > 0) chk("full_latency", out_t[0], acc0 + 1);
    for (int i = 0; i < out_d.size(); i++) begin
      chk("full_data", {16'd0, out_d[i]}, i);
      chk("full_last", {31'd0, out_l[i]}, (i == 11) ? 32'd1 : 32'd0);
      chk("full_keep", {31'd0, out_k[i]}, 32'd1);
      chk("full_no_bubble", out_t[i], out_t[0] + i);
    end

    // Null beat without last: dropped
    clear_out();
    send_beat(64'h1234_5678_9ABC_DEF0, 4'h0, 1'b0);
    chk("null_s_ready_next", {31'd0, s_ready}, 32'd1);
    chk("null_m_valid", {31'd0, m_valid}, 32'd0);
    repeat (3) cyc();
    chk("null_no_output", out_d.size(), 0);

    // Null beat with last: single marker beat
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 1'b1);
    repeat (3) cyc();
    chk("nlast_count", out_d.size(), 1);
    if (out_d.size() > 0) begin
      chk("nlast_data", {16'd0, out_d[0]}, 32'd0);
      chk("nlast_keep", {31'd0, out_k[0]}, 32'd0);
      chk("nlast_last", {31'd0, out_l[0]}, 32'd1);
    end
`ifdef AXIS_WORD_SERIALIZER_STATS_EN
    chk("stats_word_count", o_word_count, 32'd12);
    chk("stats_pkt_count", o_pkt_count, 32'd2);
`endif

    // Sparse keep 4'b1010
    clear_out();
    send_beat({16'd40, 16'd30, 16'd20, 16'd10}, 4'b1010, 1'b1);
    repeat (4) cyc();
    chk("sparse_count", out_d.size(), 2);
    if (out_d.size() == 2) begin
      chk("sparse_w0", {16'd0, out_d[0]}, 32'd20);
      chk("sparse_w1", {16'd0, out_d[1]}, 32'd40);
      chk("sparse_last0", {31'd0, out_l[0]}, 32'd0);
      chk("sparse_last1", {31'd0, out_l[1]}, 32'd1);
    end

    // Backpressure mid-beat
    clear_out();
    send_beat({16'd103, 16'd102, 16'd101, 16'd100}, 4'hF, 1'b1);
    cyc();
    m_ready = 1'b0;
    repeat (5) begin
      #1;
      chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_m_data", {16'd0, m_data}, 32'd101);
      chk("bp_m_last", {31'd0, m_last}, 32'd0);
      chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      cyc();
    end
    m_ready = 1'b1;
    repeat (5) cyc();
    chk("bp_count", out_d.size(), 4);
    for (int i = 0; i < out_d.size(); i++) begin
      chk("bp_data", {16'd0, out_d[i]}, 100 + i);
      chk("bp_last", {31'd0, out_l[i]}, (i == 3) ? 32'd1 : 32'd0);
    end

    // Random valid/ready, 101 beats = 404 words
    clear_out();
    b = 0;
    n = 0;
    while (out_d.size() < 404 && n < 30000) begin
      if (!s_valid && b < 101 && $urandom_range(99) < 5) begin
        s_valid = 1'b1;
        s_data = {16'(4*b+3), 16'(4*b+2), 16'(4*b+1), 16'(4*b)};
        s_keep = 4'hF;
        s_last = (b == 100);
      end
      m_ready = ($urandom_range(99) < 20);
      cyc();
      n++;
      if (s_acc) begin
        b++;
        s_valid = 1'b0; s_last = 1'b0; s_keep = '0;
      end
    end
    m_ready = 1'b1;
    repeat (3) cyc();
    chk("rand_count", out_d.size(), 404);
    lasts = 0;
    for (int i = 0; i < out_d.size(); i++) begin
      chk("rand_data", {16'd0, out_d[i]}, i);
      if (out_l[i]) lasts++;
    end
    chk("rand_last_count", lasts, 1);
    if (out_l.size() == 404) chk("rand_last_pos", {31'd0, out_l[403]}, 32'd1);

    // Reset while word 2 of 4 pending
    clear_out();
    send_beat({16'd203, 16'd202, 16'd201, 16'd200}, 4'hF, 1'b1);
    cyc();
    cyc();
    chk("mid_pending_word", {16'd0, m_data}, 32'd202);
    m_ready = 1'b0;
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    cyc();
    chk("mid_rst_s_ready_after", {31'd0, s_ready}, 32'd1);
    chk("mid_rst_m_valid_after", {31'd0, m_valid}, 32'd0);
    repeat (4) cyc();
    chk("mid_rst_count", out_d.size(), 2);
    clear_out();
    send_beat({16'd303, 16'd302, 16'd301, 16'd300}, 4'hF, 1'b1);
    repeat (5) cyc();
    chk("post_rst_count", out_d.size(), 4);
    for (int i = 0; i < out_d.size(); i++) begin
      chk("post_rst_data", {16'd0, out_d[i]}, 300 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
